// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and lock-table types for the memory arbiter
package mem_arbiter_pkg;
  localparam int C     = 8;
  localparam int NLOCK = 16;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int LW    = 4;
  localparam int AW    = 16;

  typedef logic [CW-1:0] core_id_t;

  typedef struct packed {
    logic     valid;
    core_id_t owner;
  } lock_entry_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin picker scanning upward from ptr
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    int   j;
    logic found;
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!found && i_req[j]) begin
        found       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
    o_any = found;
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin main_mem port arbiter with a core-to-core lock table
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [C-1:0]          i_main_mem_read_request,
  input  logic [C-1:0]          i_main_mem_write_request,
  input  logic [C-1:0][AW-1:0]  i_main_mem_read_adr,
  input  logic [C-1:0][AW-1:0]  i_main_mem_write_adr,
  input  logic [C-1:0][AW-1:0]  i_main_mem_write_dat,
  output logic [C-1:0]          o_main_mem_ac,
  output logic [AW-1:0]         o_mem_read_adr,
  output logic [AW-1:0]         o_mem_write_adr,
  output logic [AW-1:0]         o_mem_write_dat,
  output logic                  o_mem_write,
  input  logic [C-1:0][LW-1:0]  i_lock_adr,
  input  logic [C-1:0]          i_lock_en,
  input  logic [C-1:0]          i_unlock_en,
  output logic [C-1:0]          o_lock_ac,
  output logic [NLOCK-1:0]      o_lock_busy
);
  core_id_t    r_mem_ptr;
  core_id_t    r_lock_ptr;
  lock_entry_t r_table [NLOCK];

  logic [C-1:0] w_mem_req;
  logic [C-1:0] w_mem_oh;
  core_id_t     w_mem_idx;
  logic         w_mem_any;
  core_id_t     w_mem_next;

  assign w_mem_req = i_main_mem_read_request | i_main_mem_write_request;

  rr_pick #(.N(C), .IW(CW)) u_mem_pick (
    .i_req    (w_mem_req),
    .i_ptr    (r_mem_ptr),
    .o_onehot (w_mem_oh),
    .o_idx    (w_mem_idx),
    .o_any    (w_mem_any)
  );

  assign w_mem_next      = (w_mem_idx == core_id_t'(C - 1)) ? '0 : w_mem_idx + 1'b1;
  assign o_main_mem_ac   = i_reset ? '0 : w_mem_oh;
  assign o_mem_read_adr  = i_main_mem_read_adr[w_mem_idx];
  assign o_mem_write_adr = i_main_mem_write_adr[w_mem_idx];
  assign o_mem_write_dat = i_main_mem_write_dat[w_mem_idx];
  assign o_mem_write     = !i_reset && w_mem_any && i_main_mem_write_request[w_mem_idx];

  logic [NLOCK-1:0]         w_unlock_hit;
  logic [C-1:0]             w_cand;
  logic [NLOCK-1:0][C-1:0]  w_cand_at;
  logic [NLOCK-1:0][C-1:0]  w_lock_oh;
  logic [NLOCK-1:0][CW-1:0] w_lock_idx;
  logic [NLOCK-1:0]         w_lock_any;
  logic [C-1:0]             w_lock_grant;
  core_id_t                 w_lock_low;
  core_id_t                 w_lock_next;

  // An entry being released this cycle is off limits until the clear has landed.
  always_comb begin
    w_unlock_hit = '0;
    for (int i = 0; i < C; i++) begin
      if (i_unlock_en[i]) w_unlock_hit[i_lock_adr[i]] = 1'b1;
    end
    for (int i = 0; i < C; i++) begin
      w_cand[i] = i_lock_en[i] && !w_unlock_hit[i_lock_adr[i]] &&
                  (!r_table[i_lock_adr[i]].valid ||
                   r_table[i_lock_adr[i]].owner == core_id_t'(i));
    end
    for (int n = 0; n < NLOCK; n++) begin
      for (int i = 0; i < C; i++) begin
        w_cand_at[n][i] = w_cand[i] && (i_lock_adr[i] == LW'(n));
      end
    end
  end

  // One picker per table index: each index grants at most one core, indices are independent.
  for (genvar n = 0; n < NLOCK; n++) begin : g_lock
    rr_pick #(.N(C), .IW(CW)) u_lock_pick (
      .i_req    (w_cand_at[n]),
      .i_ptr    (r_lock_ptr),
      .o_onehot (w_lock_oh[n]),
      .o_idx    (w_lock_idx[n]),
      .o_any    (w_lock_any[n])
    );
  end

  always_comb begin
    w_lock_grant = '0;
    w_lock_low   = core_id_t'(C - 1);
    for (int n = 0; n < NLOCK; n++) begin
      w_lock_grant = w_lock_grant | w_lock_oh[n];
      if (w_lock_any[n] && w_lock_idx[n] < w_lock_low) w_lock_low = w_lock_idx[n];
    end
    w_lock_next = (w_lock_low == core_id_t'(C - 1)) ? '0 : w_lock_low + 1'b1;
  end

  assign o_lock_ac = i_reset ? '0 : w_lock_grant;

  always_comb begin
    for (int n = 0; n < NLOCK; n++) begin
      o_lock_busy[n] = !i_reset && r_table[n].valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_ptr  <= '0;
      r_lock_ptr <= '0;
      for (int n = 0; n < NLOCK; n++) r_table[n] <= '0;
    end else begin
      if (w_mem_any) r_mem_ptr <= w_mem_next;
      if (|w_lock_any) r_lock_ptr <= w_lock_next;
      for (int i = 0; i < C; i++) begin
        if (i_unlock_en[i] && r_table[i_lock_adr[i]].valid &&
            r_table[i_lock_adr[i]].owner == core_id_t'(i)) begin
          r_table[i_lock_adr[i]] <= '0;
        end
      end
      for (int i = 0; i < C; i++) begin
        if (w_lock_grant[i]) r_table[i_lock_adr[i]] <= '{valid: 1'b1, owner: core_id_t'(i)};
      end
    end
  end
endmodule
